proc_boot_ctrl: RTL

Sequencer that owns the processor's reset and instruction-memory write port. It holds the core in reset, loads a program image from a host byte stream into instruction memory, releases the core, and then watches `halt_o`/`err_o` to stop and report. It sits between the host link (UART/loader) and the `proc` + instruction-memory pair at the top level.

---
 rtl/proc_boot_ctrl_pkg.sv | 20 ++
 rtl/proc_boot_ctrl_byte_packer.sv | 51 +++++
 rtl/proc_boot_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/proc_boot_ctrl_pkg.sv
// rtl/proc_boot_ctrl_pkg.sv - boot sequencer types, constants and helpers
package proc_boot_ctrl_pkg;

  // Instruction word width the loader assembles; the packer assumes 4 bytes per word.
  localparam int IMEM_WIDTH_DEF  = 32;
  localparam int BOOT_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT_IDLE = 2'd0,
    BOOT_LOAD = 2'd1,
    BOOT_RUN  = 2'd2,
    BOOT_STOP = 2'd3
  } boot_state_t;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/proc_boot_ctrl_byte_packer.sv
// rtl/proc_boot_ctrl_byte_packer.sv - big-endian byte-to-word assembler
module byte_packer
  import proc_boot_ctrl_pkg::*;
#(
  parameter int WORD_W = IMEM_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int CNT_W = $clog2(BOOT_WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BOOT_WORD_BYTES - 1);

  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WORD_W-9:0] shift_q, shift_d;

  // The word completes on the last byte itself, so the strobe is combinational
  // and the caller registers it; earlier bytes sit in shift_q MSB-first.
  assign word_valid = in_valid && !clr && (byte_cnt_q == LAST_BYTE);
  assign word_data  = {shift_q, in_data};

  // Byte counter wraps naturally after the last byte; clear discards a partial word.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clr) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (in_valid) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      shift_d    = {shift_q[WORD_W-17:0], in_data};
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/proc_boot_ctrl.sv
// rtl/proc_boot_ctrl.sv - processor reset and instruction-memory load sequencer
module proc_boot_ctrl
  import proc_boot_ctrl_pkg::*;
#(
  parameter int IMEM_WIDTH  = IMEM_WIDTH_DEF,
  parameter int IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   load_start,
  input  logic [IMEM_ADDR_W:0]   load_len,
  input  logic                   abort,
  input  logic                   halt_i,
  input  logic                   err_i,
  output logic                   proc_rst_n,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_waddr,
  output logic [IMEM_WIDTH-1:0]  imem_wdata,
  output logic [1:0]             state_o,
  output logic                   load_done,
  output logic                   halted,
  output logic                   errored,
  output logic [31:0]            run_cycles
);

  localparam logic [IMEM_ADDR_W:0] MAX_LEN = {1'b1, {IMEM_ADDR_W{1'b0}}};

  boot_state_t             state_q, state_d;
  logic [IMEM_ADDR_W:0]    len_q, len_d;
  logic [IMEM_ADDR_W:0]    word_cnt_q, word_cnt_d;
  logic [31:0]             run_cycles_q, run_cycles_d;
  logic                    halted_q, halted_d;
  logic                    errored_q, errored_d;
  logic                    proc_rst_n_q, proc_rst_n_d;
  logic                    imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0]  imem_waddr_q, imem_waddr_d;
  logic [IMEM_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
  logic                    load_done_q, load_done_d;

  logic                    start_accept;
  logic                    load_busy;
  logic                    pack_clr;
  logic                    pack_in_valid;
  logic                    word_valid;
  logic [IMEM_WIDTH-1:0]   word_data;

  // Once the last word has been issued, LOAD spends one more cycle letting the
  // write commit; bytes arriving then must not start another word.
  assign start_accept  = load_start && !abort &&
                         ((state_q == BOOT_IDLE) || (state_q == BOOT_STOP));
  assign load_busy     = (state_q == BOOT_LOAD) && (word_cnt_q != len_q);
  assign pack_clr      = abort || start_accept;
  assign pack_in_valid = rx_valid && load_busy && !abort;

  byte_packer #(.WORD_W(IMEM_WIDTH)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .in_valid   (pack_in_valid),
    .in_data    (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Next-state and output logic: abort beats load_start beats stream/halt activity.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    run_cycles_d = run_cycles_q;
    halted_d     = halted_q;
    errored_d    = errored_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;

    if (abort) begin
      state_d    = BOOT_IDLE;
      word_cnt_d = '0;
    end else if (start_accept) begin
      len_d        = (load_len > MAX_LEN) ? MAX_LEN : load_len;
      word_cnt_d   = '0;
      run_cycles_d = '0;
      halted_d     = 1'b0;
      errored_d    = 1'b0;
      state_d      = (load_len == '0) ? BOOT_RUN : BOOT_LOAD;
    end else begin
      case (state_q)
        BOOT_LOAD: begin
          if (!load_busy) begin
            state_d = BOOT_RUN;
          end else if (word_valid) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = word_cnt_q[IMEM_ADDR_W-1:0];
            imem_wdata_d = word_data;
            word_cnt_d   = word_cnt_q + 1'b1;
          end
        end
        BOOT_RUN: begin
          run_cycles_d = sat_inc32(run_cycles_q);
          if (halt_i || err_i) begin
            state_d   = BOOT_STOP;
            halted_d  = halted_q | halt_i;
            errored_d = errored_q | err_i;
          end
        end
        default: begin
        end
      endcase
    end

    proc_rst_n_d = (state_d == BOOT_RUN) || (state_d == BOOT_STOP);
    load_done_d  = (state_d == BOOT_RUN) && (state_q != BOOT_RUN);
  end

  // All state and outputs are registered; reset holds the core in reset at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      run_cycles_q <= '0;
      halted_q     <= 1'b0;
      errored_q    <= 1'b0;
      proc_rst_n_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      run_cycles_q <= run_cycles_d;
      halted_q     <= halted_d;
      errored_q    <= errored_d;
      proc_rst_n_q <= proc_rst_n_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      load_done_q  <= load_done_d;
    end
  end

  assign state_o    = state_q;
  assign proc_rst_n = proc_rst_n_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign load_done  = load_done_q;
  assign halted     = halted_q;
  assign errored    = errored_q;
  assign run_cycles = run_cycles_q;

endmodule
